// File: rtl/wb_dcache.sv
// Direct-mapped, write-back, write-allocate cache between a 32-bit CPU data port
// and a 256-bit cacheline port. Flop-based storage with combinational lookup.
//
// state     | meaning
// IDLE      | waiting for cpu_read / cpu_write
// CHECK     | tag compare; a hit responds this cycle
// WRITEBACK | evicting the dirty victim line, held until mem_resp
// ALLOCATE  | filling the requested line, held until mem_resp
module wb_dcache #(
  parameter int S_INDEX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  cpu_address,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [3:0]   cpu_wmask,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_resp,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  localparam int SETS  = 2 ** S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tags  [SETS];
  logic [255:0]     lines [SETS];

  logic [S_INDEX-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         word;
  logic               unused_byte_bits;

  logic [255:0] line_sel;
  logic [31:0]  word_sel;
  logic [255:0] merged_line;
  logic         hit;
  logic         hit_write;
  logic         fill;

  assign index            = cpu_address[5 +: S_INDEX];
  assign tag              = cpu_address[31:5+S_INDEX];
  assign word             = cpu_address[4:2];
  assign unused_byte_bits = ^cpu_address[1:0];

  assign line_sel = lines[index];
  assign word_sel = line_sel[{word, 5'b0} +: 32];
  assign hit      = valid[index] && (tags[index] == tag);

  // Byte-merge the CPU write into the addressed word of the resident line.
  always_comb begin
    merged_line = line_sel;
    for (int b = 0; b < 4; b++) begin
      if (cpu_wmask[b]) begin
        merged_line[{word, b[1:0], 3'b000} +: 8] = cpu_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      if (fill) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end else if (hit_write) begin
        dirty[index] <= 1'b1;
      end
    end
  end

  // Tags and line data carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[index]  <= tag;
      lines[index] <= mem_rdata;
    end else if (hit_write) begin
      lines[index] <= merged_line;
    end
  end

  always_comb begin
    state_next  = state;
    cpu_resp    = 1'b0;
    cpu_rdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    mem_address = '0;
    hit_write   = 1'b0;
    fill        = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_read || cpu_write) state_next = CHECK;
      end
      CHECK: begin
        if (hit) begin
          cpu_resp   = 1'b1;
          cpu_rdata  = cpu_write ? '0 : word_sel;
          hit_write  = cpu_write;
          state_next = IDLE;
        end else if (valid[index] && dirty[index]) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = {tags[index], index, 5'b0};
        mem_wdata   = line_sel;
        if (mem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = {tag, index, 5'b0};
        if (mem_resp) begin
          fill       = 1'b1;
          state_next = CHECK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
